// File: rtl/io_stage.sv
// io_stage: memory-response stage between EX and WB.
// Holds one instruction, waits for load data, aligns it and forwards to WB.
//
// Ports
//   clock                  single clock, all state on posedge
//   reset                  asynchronous, active-low
//   ex_to_io_bus   [121:0] {valid, pc[31:0], final_result[31:0], mem_read,
//                           request_issued, load_type[2:0], address_low[1:0],
//                           rt_data[31:0], rf_we, rf_waddr[4:0],
//                           rf_wstrb[3:0], cp0[7:0]}
//   io_allow_in            stage can accept ex_to_io_bus this cycle
//   ex_request_in_flight   EX holds an issued, unforwarded request
//   wb_allow_in            WB accepts io_to_wb_bus
//   flush                  WB exception/eret commit, kills IO contents
//   data_sram_data_ok      load response pulse, in request order
//   data_sram_rdata [31:0] load response data
//   io_to_wb_bus   [114:0] {valid, pc, result, rt_data, rf_we, rf_waddr,
//                           rf_wstrb, cp0}
//   io_to_id_back_pass_bus [42:0]
//                          {valid, blocking, write_register[4:0],
//                           write_strobe[3:0], write_data[31:0]}
//   io_cancel_pending      responses still owed to killed instructions
//
// load_type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR.

module io_stage #(
    parameter int CANCEL_WIDTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [121:0] ex_to_io_bus,
    output logic         io_allow_in,
    input  logic         ex_request_in_flight,
    input  logic         wb_allow_in,
    input  logic         flush,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic [114:0] io_to_wb_bus,
    output logic [42:0]  io_to_id_back_pass_bus,
    output logic         io_cancel_pending
);

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [2:0] LT_LW  = 3'd4;
    localparam logic [2:0] LT_LWL = 3'd5;
    localparam logic [2:0] LT_LWR = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

    state_t                  state;
    logic                    io_valid;
    logic [120:0]            from_ex;
    logic [31:0]             rbuf;
    logic                    rbuf_valid;
    logic [CANCEL_WIDTH-1:0] cancel;

    logic [31:0] f_pc;
    logic [31:0] f_result;
    logic        f_mem_read;
    logic        f_req;
    logic [2:0]  f_load_type;
    logic [1:0]  f_addr_low;
    logic [31:0] f_rt_data;
    logic        f_rf_we;
    logic [4:0]  f_rf_waddr;
    logic [3:0]  f_rf_wstrb;
    logic [7:0]  f_cp0;

    assign {f_pc, f_result, f_mem_read, f_req, f_load_type, f_addr_low,
            f_rt_data, f_rf_we, f_rf_waddr, f_rf_wstrb, f_cp0} = from_ex;

    logic in_valid;
    logic in_need;
    assign in_valid = ex_to_io_bus[121];
    assign in_need  = ex_to_io_bus[56] && ex_to_io_bus[55];

    logic need_resp;
    logic resp_ok;
    logic resp_hit;
    logic io_ready_go;
    logic wb_valid;

    // A response belongs to us only when no killed request is still owed.
    assign resp_ok     = data_sram_data_ok && (cancel == '0);
    assign need_resp   = io_valid && f_mem_read && f_req;
    assign resp_hit    = (state == WAIT) && resp_ok;
    assign io_ready_go = !need_resp || rbuf_valid || resp_hit;
    assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
    assign wb_valid    = io_valid && io_ready_go && !flush;

    // Discard counter: on flush, our own outstanding request and any
    // request EX already issued become responses to drop.
    logic [CANCEL_WIDTH-1:0] cancel_inc;
    logic [CANCEL_WIDTH-1:0] cancel_dec;
    logic [CANCEL_WIDTH:0]   cancel_sum;
    logic [CANCEL_WIDTH-1:0] cancel_nxt;

    always_comb begin
        cancel_inc = '0;
        if (flush) begin
            cancel_inc = CANCEL_WIDTH'(ex_request_in_flight)
                       + CANCEL_WIDTH'((state == WAIT) && !resp_ok);
        end
        cancel_dec = CANCEL_WIDTH'(data_sram_data_ok && (cancel != '0));
        cancel_sum = {1'b0, cancel} + {1'b0, cancel_inc}
                   - {1'b0, cancel_dec};
        cancel_nxt = cancel_sum[CANCEL_WIDTH-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            io_valid   <= 1'b0;
            from_ex    <= '0;
            rbuf       <= '0;
            rbuf_valid <= 1'b0;
            cancel     <= '0;
        end else begin
            cancel <= cancel_nxt;
            if (flush) begin
                io_valid   <= 1'b0;
                rbuf_valid <= 1'b0;
                state      <= IDLE;
            end else if (io_allow_in) begin
                io_valid   <= in_valid;
                rbuf_valid <= 1'b0;
                if (in_valid) begin
                    from_ex <= ex_to_io_bus[120:0];
                end
                state <= (in_valid && in_need) ? WAIT : IDLE;
            end else if (resp_hit) begin
                // WB stalled: park the response until it is taken.
                rbuf       <= data_sram_rdata;
                rbuf_valid <= 1'b1;
                state      <= READY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(io_allow_in && in_valid && in_need &&
                      cancel != '0 && !flush));
            assert (cancel_sum <= (CANCEL_WIDTH + 1)'(2));
        end
    end

    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_res;
    logic [3:0]  load_strb;
    logic [31:0] res;
    logic [3:0]  strb;

    assign load_data = rbuf_valid ? rbuf : data_sram_rdata;

    always_comb begin
        byte_sel  = 8'(load_data >> {f_addr_low, 3'b000});
        half_sel  = f_addr_low[1] ? load_data[31:16] : load_data[15:0];
        load_res  = load_data;
        load_strb = 4'hF;
        unique case (f_load_type)
            LT_LB:  load_res = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU: load_res = {24'b0, byte_sel};
            LT_LH:  load_res = {{16{half_sel[15]}}, half_sel};
            LT_LHU: load_res = {16'b0, half_sel};
            LT_LW:  load_res = load_data;
            LT_LWL: begin
                load_res  = load_data << {~f_addr_low, 3'b000};
                load_strb = 4'hF << ~f_addr_low;
            end
            LT_LWR: begin
                load_res  = load_data >> {f_addr_low, 3'b000};
                load_strb = 4'hF >> f_addr_low;
            end
            default: load_res = load_data;
        endcase
        res  = f_mem_read ? load_res  : f_result;
        strb = f_mem_read ? load_strb : f_rf_wstrb;
    end

    assign io_to_wb_bus = {wb_valid, f_pc, res, f_rt_data, f_rf_we,
                           f_rf_waddr, strb, f_cp0};

    assign io_to_id_back_pass_bus = {io_valid && f_rf_we,
                                     need_resp && !io_ready_go,
                                     f_rf_waddr, strb, res};

    assign io_cancel_pending = (cancel != '0);

endmodule

// File: tb/tb_io_stage.sv
// tb_io_stage: directed + random bench for io_stage.
// Expected values come from an arithmetic model of the load rules.

module tb_io_stage;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LBU = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LHU = 3'd3;
    localparam logic [2:0] LW  = 3'd4;
    localparam logic [2:0] LWL = 3'd5;
    localparam logic [2:0] LWR = 3'd6;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [121:0] ex_to_io_bus = '0;
    logic         io_allow_in;
    logic         ex_request_in_flight = 1'b0;
    logic         wb_allow_in = 1'b1;
    logic         flush = 1'b0;
    logic         data_sram_data_ok = 1'b0;
    logic [31:0]  data_sram_rdata = '0;
    logic [114:0] io_to_wb_bus;
    logic [42:0]  io_to_id_back_pass_bus;
    logic         io_cancel_pending;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    io_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .ex_to_io_bus           (ex_to_io_bus),
        .io_allow_in            (io_allow_in),
        .ex_request_in_flight   (ex_request_in_flight),
        .wb_allow_in            (wb_allow_in),
        .flush                  (flush),
        .data_sram_data_ok      (data_sram_data_ok),
        .data_sram_rdata        (data_sram_rdata),
        .io_to_wb_bus           (io_to_wb_bus),
        .io_to_id_back_pass_bus (io_to_id_back_pass_bus),
        .io_cancel_pending      (io_cancel_pending)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {strobe, data} for a load, straight from the byte-lane rules.
    function automatic logic [35:0] ref_align(logic [2:0] lt,
                                              logic [1:0] b,
                                              logic [31:0] r);
        int bi;
        logic [31:0] d;
        logic [3:0] s;
        bi = int'(b);
        s = 4'hF;
        d = r;
        case (lt)
            LB, LBU: begin
                d = (r >> (8 * bi)) & 32'hFF;
                if (lt == LB && d >= 128) d = d - 32'd256;
            end
            LH, LHU: begin
                d = (r >> (16 * (bi / 2))) & 32'hFFFF;
                if (lt == LH && d >= 32768) d = d - 32'd65536;
            end
            LWL: begin
                d = r << (8 * (3 - bi));
                s = 4'(((1 << (bi + 1)) - 1) << (3 - bi));
            end
            LWR: begin
                d = r >> (8 * bi);
                s = 4'(15 >> bi);
            end
            default: d = r;
        endcase
        return {s, d};
    endfunction

    function automatic logic [121:0] mk_ex(
        logic [31:0] pc, logic [31:0] res, logic mr, logic [2:0] lt,
        logic [1:0] al, logic [31:0] rt, logic we, logic [4:0] wa,
        logic [3:0] ws, logic [7:0] cp0);
        return {1'b1, pc, res, mr, mr, lt, al, rt, we, wa, ws, cp0};
    endfunction

    function automatic logic [114:0] exp_wb(logic [121:0] ex,
                                            logic [31:0] r);
        logic [35:0] a;
        logic [31:0] d;
        logic [3:0] s;
        a = ref_align(ex[54:52], ex[51:50], r);
        if (ex[56]) begin
            s = a[35:32];
            d = a[31:0];
        end else begin
            s = ex[11:8];
            d = ex[88:57];
        end
        return {1'b1, ex[120:89], d, ex[49:18], ex[17], ex[16:12], s,
                ex[7:0]};
    endfunction

    // One instruction through IO: accept, wait dly cycles, respond,
    // then hold for stall cycles with WB refusing.
    task automatic run(input logic [121:0] ex, input int dly,
                       input int stall, input logic [31:0] r,
                       input string tag);
        logic need;
        logic [114:0] w;
        logic [42:0] bp;
        need = ex[56] && ex[55];
        w = exp_wb(ex, r);
        bp = {w[17], 1'b0, w[16:12], w[11:8], w[81:50]};
        ex_to_io_bus = ex;
        data_sram_data_ok = 1'b0;
        wb_allow_in = 1'b1;
        #1 chk({tag, ".accept"}, 128'(io_allow_in), 128'(1));
        tick();
        ex_to_io_bus = '0;
        if (need) begin
            for (int d = 0; d < dly; d++) begin
                #1 chk({tag, ".block"},
                       128'({io_to_id_back_pass_bus[41], io_to_wb_bus[114]}),
                       128'(2'b10));
                tick();
            end
        end
        data_sram_data_ok = need;
        data_sram_rdata = r;
        wb_allow_in = (stall == 0);
        #1 chk({tag, ".wb"}, 128'(io_to_wb_bus), 128'(w));
        chk({tag, ".bp"}, 128'(io_to_id_back_pass_bus), 128'(bp));
        tick();
        data_sram_data_ok = 1'b0;
        for (int s = 1; s <= stall; s++) begin
            data_sram_rdata = $urandom;
            wb_allow_in = (s == stall);
            #1 chk({tag, ".hold"}, 128'(io_to_wb_bus), 128'(w));
            chk({tag, ".stall"}, 128'(io_allow_in), 128'(s == stall));
            tick();
        end
        wb_allow_in = 1'b1;
        #1 chk({tag, ".drain"}, 128'(io_to_wb_bus[114]), 128'(0));
    endtask

    function automatic logic [4:0] status();
        return {io_to_wb_bus[114], io_to_id_back_pass_bus[42:41],
                io_allow_in, io_cancel_pending};
    endfunction

    initial begin
        int owed;
        logic [121:0] ld;

        #1 reset = 1'b0;
        #1 chk("rst.state", 128'(status()), 128'(5'b00010));
        tick();
        tick();
        reset = 1'b1;
        tick();

        run(mk_ex(32'h400, 32'h1000, 1, LW, 2'd0, 32'h0, 1, 5'd2,
                  4'hF, 8'h0), 3, 0, 32'h8899AABB, "lw");
        run(mk_ex(32'h404, 32'h1001, 1, LB, 2'd1, 32'h0, 1, 5'd3,
                  4'hF, 8'h0), 1, 0, 32'h0000F300, "lb");
        run(mk_ex(32'h408, 32'h1001, 1, LBU, 2'd1, 32'h0, 1, 5'd4,
                  4'hF, 8'h0), 0, 0, 32'h0000F300, "lbu");
        run(mk_ex(32'h40C, 32'h1002, 1, LH, 2'd2, 32'h0, 1, 5'd5,
                  4'hF, 8'h0), 2, 0, 32'h80010000, "lh");
        run(mk_ex(32'h410, 32'h1001, 1, LWL, 2'd1, 32'h0, 1, 5'd6,
                  4'hF, 8'h0), 1, 0, 32'h11223344, "lwl");
        run(mk_ex(32'h414, 32'h1002, 1, LWR, 2'd2, 32'h0, 1, 5'd7,
                  4'hF, 8'h0), 1, 0, 32'h11223344, "lwr");
        run(mk_ex(32'h418, 32'h1004, 1, LW, 2'd0, 32'h0, 1, 5'd8,
                  4'hF, 8'h0), 1, 4, 32'hCAFEF00D, "stall");
        run(mk_ex(32'h41C, 32'hDEADBEEF, 0, LW, 2'd0, 32'h5, 1, 5'd9,
                  4'h5, 8'hA5), 0, 2, 32'h0, "alu");

        // Flush while waiting with EX also holding a request.
        owed = 0;
        ld = mk_ex(32'h500, 32'h2000, 1, LW, 2'd0, 32'h0, 1, 5'd10,
                   4'hF, 8'h0);
        ex_to_io_bus = ld;
        tick();
        ex_to_io_bus = '0;
        tick();
        flush = 1'b1;
        ex_request_in_flight = 1'b1;
        owed = owed + 1 + 1;
        #1 chk("fl.kill", 128'(io_to_wb_bus[114]), 128'(0));
        tick();
        flush = 1'b0;
        ex_request_in_flight = 1'b0;
        #1 chk("fl.pend", 128'(status()), 128'({4'b0001, owed != 0}));
        for (int k = 1; k <= 2; k++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata = 32'hBAD00000 + 32'(k);
            #1 chk("fl.nofwd", 128'(io_to_wb_bus[114]), 128'(0));
            tick();
            data_sram_data_ok = 1'b0;
            owed = owed - 1;
            #1 chk("fl.drop", 128'(io_cancel_pending), 128'(owed != 0));
        end
        run(mk_ex(32'h504, 32'h2004, 1, LW, 2'd0, 32'h0, 1, 5'd11,
                  4'hF, 8'h0), 1, 0, 32'h55667788, "fl.new");

        // Flush and data_ok together with nothing owed.
        ex_to_io_bus = ld;
        tick();
        ex_to_io_bus = '0;
        tick();
        flush = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h12345678;
        #1 chk("fd.kill", 128'(io_to_wb_bus[114]), 128'(0));
        tick();
        flush = 1'b0;
        data_sram_data_ok = 1'b0;
        #1 chk("fd.clean", 128'(status()), 128'(5'b00010));
        run(mk_ex(32'h508, 32'h2008, 1, LHU, 2'd2, 32'h0, 1, 5'd12,
                  4'hF, 8'h0), 2, 0, 32'h9ABC0000, "fd.new");

        // Flush with data_ok while a response is already owed.
        owed = 0;
        flush = 1'b1;
        ex_request_in_flight = 1'b1;
        tick();
        owed = owed + 1;
        data_sram_data_ok = 1'b1;
        tick();
        owed = owed + 1 - 1;
        flush = 1'b0;
        ex_request_in_flight = 1'b0;
        data_sram_data_ok = 1'b0;
        #1 chk("net.keep", 128'(io_cancel_pending), 128'(owed != 0));
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        owed = owed - 1;
        #1 chk("net.drain", 128'(io_cancel_pending), 128'(owed != 0));
        flush = 1'b1;
        ex_request_in_flight = 1'b1;
        tick();
        flush = 1'b0;
        ex_request_in_flight = 1'b0;
        #1 chk("net.one", 128'(io_cancel_pending), 128'(1));
        reset = 1'b0;
        #1 chk("rs.cancel", 128'(status()), 128'(5'b00010));
        tick();
        reset = 1'b1;
        tick();

        // Asynchronous reset in the middle of a wait.
        ex_to_io_bus = ld;
        tick();
        ex_to_io_bus = '0;
        #1 chk("rs.wait", 128'(status()), 128'(5'b01100));
        reset = 1'b0;
        #1 chk("rs.async", 128'(status()), 128'(5'b00010));
        tick();
        reset = 1'b1;
        tick();
        run(mk_ex(32'h600, 32'h3003, 1, LB, 2'd3, 32'h0, 1, 5'd13,
                  4'hF, 8'h0), 1, 1, 32'h7F000000, "rs.new");

        for (int i = 0; i < 40; i++) begin
            logic [2:0] lt;
            logic [1:0] al;
            logic mr;
            mr = ($urandom_range(0, 3) != 0);
            lt = 3'($urandom_range(0, 6));
            al = 2'($urandom);
            if (lt == LH || lt == LHU) al[0] = 1'b0;
            if (lt == LW) al = 2'd0;
            run(mk_ex($urandom, $urandom, mr, lt, al, $urandom,
                      1'($urandom), 5'($urandom), 4'($urandom),
                      8'($urandom)),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
